wb_traffic_gen: RTL
===================

# wb_traffic_gen

Synthesizable Wishbone B3 master that generates write, read, and write-then-verify traffic into the SDRAM controller's Wishbone slave port (wb_* signals). It produces incrementing-address bursts with a reproducible LFSR data pattern and checks read data against the same pattern. Its status outputs give the whitebox bench and on-chip self-test a pass/fail result without a behavioural master.

## Interface
Parameters:
- APP_AW, 26, Wishbone byte-address width
- dw, 32, data width (fixed at 32 for this block)
- TIMEOUT, 1024, maximum wait cycles for wb_ack_i per beat

Ports:
- wb_clk_i  in  1  Wishbone clock; all logic on its rising edge
- wb_resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a run; sampled only in IDLE
- cfg_mode  in  2  00 write-only, 01 read-only/check, 10 write-then-read-check, 11 reserved (treated as 10)
- cfg_base_addr  in  APP_AW  start byte address; bits [1:0] ignored (forced 0)
- cfg_num_words  in  16  total 32-bit words per phase
- cfg_burst_len  in  4  words per burst, 1..8; 0 treated as 1, >8 clamped to 8
- cfg_seed  in  32  LFSR seed; 0 replaced by 32'h1
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls
- wb_addr_o  out  APP_AW  byte address
- wb_dat_o  out  dw  write data
- wb_sel_o  out  4  byte enables; always 4'hF during a cycle, 0 otherwise
- wb_cti_o  out  3  cycle type
- wb_ack_i  in  1  slave acknowledge
- wb_dat_i  in  dw  read data
- busy  out  1  run in progress
- done  out  1  run finished; held until next accepted start
- timeout  out  1  run aborted on ack timeout; held with done
- err_cnt  out  16  read mismatches, saturating at 16'hFFFF
- first_err_addr  out  APP_AW  byte address of the first mismatch

## Operation
- FSM states: IDLE, WR_BURST, WR_GAP, RD_BURST, RD_GAP, DONE.
- IDLE + start: latch all cfg_*, clear done/timeout/err_cnt/first_err_addr, load LFSR with the seed, load address with cfg_base_addr.
  - If cfg_num_words == 0: go directly to DONE with no bus cycle.
  - Otherwise mode 01 goes to RD_BURST; all other modes go to WR_BURST.
- Burst length = min(cfg_burst_len, words remaining).
- wb_cti_o per beat:
  - 3'b000 when burst length is 1.
  - 3'b010 for every beat except the last.
  - 3'b111 on the last beat.
- Each beat: wb_cyc_o = wb_stb_o = 1 until wb_ack_i. On ack, address += 4 (wraps modulo 2^APP_AW), LFSR advances one step, remaining word count decrements.
- LFSR: 32-bit Galois, taps 32'h80200003, shift right. Write data = current LFSR value.
- WR_BURST: wb_we_o = 1. After the last ack of a burst, go to WR_GAP.
- WR_GAP: if words remain, return to WR_BURST. Otherwise:
  - mode 00: go to DONE.
  - else: reload LFSR with the seed, reload address with cfg_base_addr, go to RD_BURST.
- RD_BURST: wb_we_o = 0. On each ack, compare wb_dat_i with the LFSR value.
  - On mismatch: err_cnt++ (saturating); on the first mismatch only, capture wb_addr_o into first_err_addr.
- RD_GAP: if words remain, go to RD_BURST; else go to DONE.
- Ack timeout: a per-beat counter reaches TIMEOUT with no ack. Drop cyc/stb, set timeout = 1, go to DONE.
- DONE: done = 1, busy = 0. A new start re-arms and follows the IDLE rules.
- start while busy is ignored. wb_ack_i while cyc is low is ignored.

## Timing
- All outputs are registered.
- Reset values: cyc/stb/we = 0, addr = 0, dat = 0, sel = 0, cti = 0, busy = 0, done = 0, timeout = 0, err_cnt = 0, first_err_addr = 0, FSM = IDLE.
- Asserting reset mid-run drops cyc/stb asynchronously. The run is lost; no completion is reported.
- start at edge N: busy = 1 and cyc/stb = 1 from N+1, with beat 0 presented.
- Ack sampled at edge M: the next beat's address, data, and cti are valid from M+1 within the same burst. Back-to-back acks give one word per cycle.
- After a burst's last ack, cyc/stb are low for exactly one cycle (GAP) before the next burst.
- Latencies:
  - write→read phase turnaround: 1 gap cycle.
  - last ack → done: done = 1 and busy = 0 from the next edge after the GAP cycle.
  - cfg_num_words == 0: done at start+1.
- Timeout: the counter resets on every ack and on burst entry. Abort happens at the TIMEOUT-th waiting cycle; done/timeout are set on the following edge.

## Test plan
- Mode 10, base 0x100, num 8, burst 4, seed 0x1, zero-wait slave model: two 4-beat write bursts with cti 010,010,010,111 and addresses 0x100..0x11C, then identical reads. Expect err_cnt = 0, done = 1, timeout = 0.
- Mode 10, num 5, burst 4, slave corrupts read word 2 (XOR 1): bursts of 4 and 1 (single uses cti 000). Expect err_cnt = 1 and first_err_addr = base + 8.
- Slave never acks, TIMEOUT = 16: exactly 16 waiting cycles with stb high, then cyc drops. Expect done = 1, timeout = 1.
- Mode 00, num 0: no cyc asserted; done high 1 cycle after start.
- Base 0x3FFFFFC, num 2, burst 2: second beat address wraps to 0x0000000.
- Reset pulsed in the middle of a read burst: cyc/stb/busy drop immediately; a later start runs a clean pass with err_cnt = 0.

Source files
------------

// File: rtl/wb_traffic_gen.sv
// rtl/wb_traffic_gen.sv - Wishbone B3 burst traffic generator with LFSR data pattern and read-back check
module wb_traffic_gen #(
  parameter int APP_AW  = 26,
  parameter int dw      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_resetn,
  input  logic              start,
  input  logic [1:0]        cfg_mode,
  input  logic [APP_AW-1:0] cfg_base_addr,
  input  logic [15:0]       cfg_num_words,
  input  logic [3:0]        cfg_burst_len,
  input  logic [31:0]       cfg_seed,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [3:0]        wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [APP_AW-1:0] first_err_addr
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {IDLE, WR_BURST, WR_GAP, RD_BURST, RD_GAP, DONE} state_t;
  state_t state, state_nxt;

  logic              cyc_nxt, we_nxt, busy_nxt, done_nxt, tmo_nxt;
  logic [APP_AW-1:0] addr_nxt, fea_nxt, base_q, base_nxt;
  logic [31:0]       lfsr, lfsr_nxt, seed_q, seed_nxt;
  logic [2:0]        cti_nxt;
  logic [15:0]       err_nxt, num_q, num_nxt, remain, remain_nxt;
  logic [1:0]        mode_q, mode_nxt;
  logic [3:0]        blen_q, blen_nxt, beats, beats_nxt;
  logic [WW-1:0]     wait_cnt, wait_nxt;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 32'h0);
  endfunction

  function automatic logic [3:0] clamp_len(input logic [3:0] b);
    if (b == 4'd0) return 4'd1;
    if (b > 4'd8) return 4'd8;
    return b;
  endfunction

  function automatic logic [3:0] burst_of(input logic [15:0] rem, input logic [3:0] blen);
    return (rem < {12'd0, blen}) ? rem[3:0] : blen;
  endfunction

  function automatic logic [2:0] first_cti(input logic [3:0] len);
    return (len == 4'd1) ? 3'b000 : 3'b010;
  endfunction

  assign wb_dat_o = lfsr;

  always_comb begin
    state_nxt  = state;
    cyc_nxt    = wb_cyc_o;
    we_nxt     = wb_we_o;
    addr_nxt   = wb_addr_o;
    lfsr_nxt   = lfsr;
    cti_nxt    = wb_cti_o;
    busy_nxt   = busy;
    done_nxt   = done;
    tmo_nxt    = timeout;
    err_nxt    = err_cnt;
    fea_nxt    = first_err_addr;
    mode_nxt   = mode_q;
    base_nxt   = base_q;
    num_nxt    = num_q;
    blen_nxt   = blen_q;
    seed_nxt   = seed_q;
    remain_nxt = remain;
    beats_nxt  = beats;
    wait_nxt   = wait_cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          mode_nxt   = cfg_mode;
          base_nxt   = cfg_base_addr & ~APP_AW'(3);
          num_nxt    = cfg_num_words;
          blen_nxt   = clamp_len(cfg_burst_len);
          seed_nxt   = (cfg_seed == 32'h0) ? 32'h1 : cfg_seed;
          done_nxt   = 1'b0;
          tmo_nxt    = 1'b0;
          err_nxt    = 16'h0;
          fea_nxt    = '0;
          lfsr_nxt   = seed_nxt;
          addr_nxt   = base_nxt;
          remain_nxt = cfg_num_words;
          if (cfg_num_words == 16'h0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt = (cfg_mode == 2'b01) ? RD_BURST : WR_BURST;
            busy_nxt  = 1'b1;
            cyc_nxt   = 1'b1;
            we_nxt    = (cfg_mode != 2'b01);
            beats_nxt = burst_of(cfg_num_words, blen_nxt);
            cti_nxt   = first_cti(beats_nxt);
            wait_nxt  = '0;
          end
        end
      end
      WR_BURST, RD_BURST: begin
        if (wb_ack_i) begin
          addr_nxt   = wb_addr_o + APP_AW'(4);
          lfsr_nxt   = lfsr_step(lfsr);
          remain_nxt = remain - 16'd1;
          wait_nxt   = '0;
          if (state == RD_BURST && wb_dat_i != lfsr) begin
            if (err_cnt != 16'hFFFF) err_nxt = err_cnt + 16'd1;
            if (err_cnt == 16'h0) fea_nxt = wb_addr_o;
          end
          if (beats == 4'd1) begin
            cyc_nxt   = 1'b0;
            we_nxt    = 1'b0;
            cti_nxt   = 3'b000;
            state_nxt = (state == WR_BURST) ? WR_GAP : RD_GAP;
          end else begin
            beats_nxt = beats - 4'd1;
            cti_nxt   = (beats == 4'd2) ? 3'b111 : 3'b010;
          end
        end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
          cyc_nxt   = 1'b0;
          we_nxt    = 1'b0;
          cti_nxt   = 3'b000;
          tmo_nxt   = 1'b1;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = DONE;
        end else begin
          wait_nxt = wait_cnt + WW'(1);
        end
      end
      WR_GAP: begin
        if (remain != 16'h0) begin
          state_nxt = WR_BURST;
          cyc_nxt   = 1'b1;
          we_nxt    = 1'b1;
          beats_nxt = burst_of(remain, blen_q);
          cti_nxt   = first_cti(beats_nxt);
          wait_nxt  = '0;
        end else if (mode_q == 2'b00) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          // Read-back replays the identical pattern from the start of the region
          lfsr_nxt   = seed_q;
          addr_nxt   = base_q;
          remain_nxt = num_q;
          state_nxt  = RD_BURST;
          cyc_nxt    = 1'b1;
          we_nxt     = 1'b0;
          beats_nxt  = burst_of(num_q, blen_q);
          cti_nxt    = first_cti(beats_nxt);
          wait_nxt   = '0;
        end
      end
      RD_GAP: begin
        if (remain != 16'h0) begin
          state_nxt = RD_BURST;
          cyc_nxt   = 1'b1;
          we_nxt    = 1'b0;
          beats_nxt = burst_of(remain, blen_q);
          cti_nxt   = first_cti(beats_nxt);
          wait_nxt  = '0;
        end else begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state          <= IDLE;
      wb_cyc_o       <= 1'b0;
      wb_stb_o       <= 1'b0;
      wb_we_o        <= 1'b0;
      wb_addr_o      <= '0;
      wb_sel_o       <= 4'h0;
      wb_cti_o       <= 3'b000;
      lfsr           <= 32'h0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= 16'h0;
      first_err_addr <= '0;
      mode_q         <= 2'b00;
      base_q         <= '0;
      num_q          <= 16'h0;
      blen_q         <= 4'd1;
      seed_q         <= 32'h1;
      remain         <= 16'h0;
      beats          <= 4'd0;
      wait_cnt       <= '0;
    end else begin
      state          <= state_nxt;
      wb_cyc_o       <= cyc_nxt;
      wb_stb_o       <= cyc_nxt;
      wb_we_o        <= we_nxt;
      wb_addr_o      <= addr_nxt;
      wb_sel_o       <= {4{cyc_nxt}};
      wb_cti_o       <= cti_nxt;
      lfsr           <= lfsr_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      timeout        <= tmo_nxt;
      err_cnt        <= err_nxt;
      first_err_addr <= fea_nxt;
      mode_q         <= mode_nxt;
      base_q         <= base_nxt;
      num_q          <= num_nxt;
      blen_q         <= blen_nxt;
      seed_q         <= seed_nxt;
      remain         <= remain_nxt;
      beats          <= beats_nxt;
      wait_cnt       <= wait_nxt;
    end
  end
endmodule
